// File: rtl/byte_pair_demux_pkg.sv
// Shared FSM encodings, select constants and word assembly helper for the
// byte pair demultiplexer.
package byte_pair_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALF = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic SEL_LOW  = 1'b0;
  localparam logic SEL_HIGH = 1'b1;

  // Places the two captured bytes into {high, low} according to arrival order.
  function automatic logic [15:0] assemble_word(input logic       low_first,
                                                input logic [7:0] first_byte,
                                                input logic [7:0] second_byte);
    return low_first ? {second_byte, first_byte} : {first_byte, second_byte};
  endfunction

endpackage

// File: rtl/byte_pair_demux_if.sv
// Byte bus, word handshake and error-flag signals of the byte pair demux.
// master = bus/consumer side, slave = demux side.
interface byte_pair_demux_if;
  logic [7:0]  data_in;
  logic        select;
  logic        out_control;
  logic        strobe;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        overrun;
  logic        seq_error;
  logic        clear_err;

  modport master (
    output data_in, select, out_control, strobe, word_ready, clear_err,
    input  word_out, word_valid, overrun, seq_error
  );

  modport slave (
    input  data_in, select, out_control, strobe, word_ready, clear_err,
    output word_out, word_valid, overrun, seq_error
  );
endinterface

// File: rtl/strobe_edge_detect.sv
// Single-cycle rising-edge pulse from a synchronous strobe level. A level
// already high when reset releases must fall once before an edge is accepted.
module strobe_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic level_q;
  logic armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      level_q <= level;
      if (!level) armed <= 1'b1;
    end
  end

  assign rise = level & ~level_q & armed;

endmodule

// File: rtl/byte_pair_demux.sv
// Reassembles 16-bit words from two strobed bytes on a muxed 8-bit bus,
// holding each word until the consumer handshakes it.
module byte_pair_demux
  import byte_pair_demux_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input logic             clk,
  input logic             reset_n,
  byte_pair_demux_if.slave bus
);

  localparam logic FIRST_SEL  = LOW_FIRST ? SEL_LOW : SEL_HIGH;
  localparam logic SECOND_SEL = ~FIRST_SEL;

  state_t      state;
  logic [7:0]  first_byte;
  logic [15:0] word_r;
  logic        valid_r;
  logic        overrun_r;
  logic        seq_error_r;
  logic        strobe_rise;
  logic        capture;
  logic        is_first;

  strobe_edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (bus.strobe),
    .rise    (strobe_rise)
  );

  assign capture  = strobe_rise & ~bus.out_control;
  assign is_first = (bus.select == FIRST_SEL);

  // Flag sets are written after clear_err so a coincident event keeps the flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      first_byte  <= 8'h00;
      word_r      <= 16'h0000;
      valid_r     <= 1'b0;
      overrun_r   <= 1'b0;
      seq_error_r <= 1'b0;
    end else begin
      if (bus.clear_err) begin
        overrun_r   <= 1'b0;
        seq_error_r <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (capture) begin
            if (is_first) begin
              first_byte <= bus.data_in;
              state      <= HALF;
            end else begin
              seq_error_r <= 1'b1;
            end
          end
        end
        HALF: begin
          if (capture) begin
            if (bus.select == SECOND_SEL) begin
              word_r  <= assemble_word(LOW_FIRST, first_byte, bus.data_in);
              valid_r <= 1'b1;
              state   <= HOLD;
            end else begin
              seq_error_r <= 1'b1;
              first_byte  <= bus.data_in;
            end
          end
        end
        HOLD: begin
          if (bus.word_ready) begin
            valid_r <= 1'b0;
            state   <= IDLE;
            if (capture) begin
              if (is_first) begin
                first_byte <= bus.data_in;
                state      <= HALF;
              end else begin
                seq_error_r <= 1'b1;
              end
            end
          end else if (capture) begin
            overrun_r <= 1'b1;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.word_out   = word_r;
  assign bus.word_valid = valid_r;
  assign bus.overrun    = overrun_r;
  assign bus.seq_error  = seq_error_r;

endmodule

// File: tb/tb_byte_pair_demux.sv
// Directed bench for byte_pair_demux: one instance per byte order, driven on
// the falling edge and sampled on the falling edge.
module tb_byte_pair_demux;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  byte_pair_demux_if a ();
  byte_pair_demux_if b ();

  byte_pair_demux #(.LOW_FIRST(1'b1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a.slave));
  byte_pair_demux #(.LOW_FIRST(1'b0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(b.slave));

  always #5 clk = ~clk;

  // One strobe pulse lasting one clock; returns on the falling edge after capture.
  task automatic pulse(input bit which, input logic sel, input logic [7:0] d);
    @(negedge clk);
    if (!which) begin a.select = sel; a.data_in = d; a.strobe = 1'b1; end
    else        begin b.select = sel; b.data_in = d; b.strobe = 1'b1; end
    @(negedge clk);
    if (!which) a.strobe = 1'b0; else b.strobe = 1'b0;
  endtask

  task automatic consume_and_clear();
    @(negedge clk);
    a.word_ready = 1'b1; a.clear_err = 1'b1;
    @(negedge clk);
    a.word_ready = 1'b0; a.clear_err = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (a.word_out !== 16'h0000) begin errors++; $display("FAIL reset_word_a: got %h want 0000", a.word_out); end
    checks++; if (a.word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b want 0", a.word_valid); end
    checks++; if ({a.overrun, a.seq_error} !== 2'b00) begin errors++; $display("FAIL reset_flags_a: got %b want 00", {a.overrun, a.seq_error}); end
    checks++; if ({b.word_out, b.word_valid} !== 17'h0) begin errors++; $display("FAIL reset_b: got %h want 0", {b.word_out, b.word_valid}); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_word_assembly();
    pulse(0, 1'b0, 8'b1011_0001);
    @(negedge clk);
    a.select = 1'b1; a.data_in = 8'b0010_0100; a.strobe = 1'b1;
    checks++; if (a.word_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b want 0", a.word_valid); end
    @(negedge clk);
    a.strobe = 1'b0;
    checks++; if (a.word_out !== 16'h24B1) begin errors++; $display("FAIL word_low_first: got %h want 24b1", a.word_out); end
    checks++; if (a.word_valid !== 1'b1) begin errors++; $display("FAIL valid_latency: got %b want 1", a.word_valid); end
    checks++; if ({a.overrun, a.seq_error} !== 2'b00) begin errors++; $display("FAIL word_flags: got %b want 00", {a.overrun, a.seq_error}); end
  endtask

  task automatic test_overrun();
    pulse(0, 1'b0, 8'h5A);
    checks++; if (a.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", a.overrun); end
    checks++; if (a.word_out !== 16'h24B1) begin errors++; $display("FAIL overrun_word_kept: got %h want 24b1", a.word_out); end
    @(negedge clk); a.word_ready = 1'b1;
    @(negedge clk); a.word_ready = 1'b0;
    checks++; if (a.word_valid !== 1'b0) begin errors++; $display("FAIL consume_valid: got %b want 0", a.word_valid); end
    checks++; if (a.word_out !== 16'h24B1) begin errors++; $display("FAIL word_retained: got %h want 24b1", a.word_out); end
    @(negedge clk); a.clear_err = 1'b1;
    @(negedge clk); a.clear_err = 1'b0;
    checks++; if (a.overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", a.overrun); end
  endtask

  task automatic test_seq_error();
    pulse(0, 1'b1, 8'h66);
    checks++; if (a.seq_error !== 1'b1) begin errors++; $display("FAIL idle_seq_error: got %b want 1", a.seq_error); end
    checks++; if (a.word_valid !== 1'b0) begin errors++; $display("FAIL idle_no_word: got %b want 0", a.word_valid); end
    @(negedge clk); a.clear_err = 1'b1;
    @(negedge clk); a.clear_err = 1'b0;
    checks++; if (a.seq_error !== 1'b0) begin errors++; $display("FAIL seq_clear: got %b want 0", a.seq_error); end
    @(negedge clk);
    a.clear_err = 1'b1; a.select = 1'b1; a.data_in = 8'h67; a.strobe = 1'b1;
    @(negedge clk);
    a.clear_err = 1'b0; a.strobe = 1'b0;
    checks++; if (a.seq_error !== 1'b1) begin errors++; $display("FAIL set_beats_clear: got %b want 1", a.seq_error); end
    consume_and_clear();
  endtask

  task automatic test_half_reselect();
    pulse(0, 1'b0, 8'h11);
    pulse(0, 1'b0, 8'h22);
    checks++; if ({a.seq_error, a.word_valid} !== 2'b10) begin errors++; $display("FAIL half_reselect: got %b want 10", {a.seq_error, a.word_valid}); end
    pulse(0, 1'b1, 8'h33);
    checks++; if (a.word_out !== 16'h3322) begin errors++; $display("FAIL half_overwrite: got %h want 3322", a.word_out); end
    consume_and_clear();
    checks++; if ({a.word_valid, a.seq_error} !== 2'b00) begin errors++; $display("FAIL half_cleanup: got %b want 00", {a.word_valid, a.seq_error}); end
  endtask

  task automatic test_out_control();
    a.out_control = 1'b1;
    for (int i = 0; i < 4; i++) pulse(0, i[0], 8'hC0 + 8'(i));
    checks++; if ({a.word_valid, a.overrun, a.seq_error} !== 3'b000) begin errors++; $display("FAIL oc_ignored: got %b want 000", {a.word_valid, a.overrun, a.seq_error}); end
    a.out_control = 1'b0;
    pulse(0, 1'b0, 8'h01);
    pulse(0, 1'b1, 8'h02);
    checks++; if (a.word_out !== 16'h0201 || a.word_valid !== 1'b1) begin errors++; $display("FAIL oc_after: got %h/%b want 0201/1", a.word_out, a.word_valid); end
    consume_and_clear();
  endtask

  task automatic test_back_to_back();
    pulse(0, 1'b0, 8'hAA);
    pulse(0, 1'b1, 8'h55);
    checks++; if (a.word_out !== 16'h55AA) begin errors++; $display("FAIL b2b_first: got %h want 55aa", a.word_out); end
    @(negedge clk);
    a.word_ready = 1'b1; a.select = 1'b0; a.data_in = 8'h0F; a.strobe = 1'b1;
    @(negedge clk);
    a.word_ready = 1'b0; a.strobe = 1'b0;
    checks++; if ({a.word_valid, a.overrun} !== 2'b00) begin errors++; $display("FAIL b2b_consume: got %b want 00", {a.word_valid, a.overrun}); end
    pulse(0, 1'b1, 8'hF0);
    checks++; if (a.word_out !== 16'hF00F || a.word_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%b want f00f/1", a.word_out, a.word_valid); end
    consume_and_clear();
  endtask

  task automatic test_reset_mid();
    pulse(0, 1'b0, 8'h99);
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    checks++; if (a.word_out !== 16'h0000 || a.word_valid !== 1'b0) begin errors++; $display("FAIL reset_half: got %h/%b want 0000/0", a.word_out, a.word_valid); end
    #1 reset_n = 1'b1;
    pulse(0, 1'b1, 8'h77);
    checks++; if ({a.seq_error, a.word_valid} !== 2'b10) begin errors++; $display("FAIL partial_discarded: got %b want 10", {a.seq_error, a.word_valid}); end
    consume_and_clear();
    pulse(0, 1'b0, 8'hB1);
    pulse(0, 1'b1, 8'h24);
    pulse(0, 1'b0, 8'h12);
    checks++; if ({a.word_valid, a.overrun} !== 2'b11) begin errors++; $display("FAIL hold_before_reset: got %b want 11", {a.word_valid, a.overrun}); end
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    checks++; if ({a.word_out, a.word_valid, a.overrun, a.seq_error} !== 19'h0) begin errors++; $display("FAIL reset_hold: got %h want 0", {a.word_out, a.word_valid, a.overrun, a.seq_error}); end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_strobe_across_reset();
    @(negedge clk);
    reset_n = 1'b0; a.select = 1'b1; a.strobe = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a.seq_error !== 1'b0) begin errors++; $display("FAIL held_strobe: got %b want 0", a.seq_error); end
    a.strobe = 1'b0;
    @(negedge clk); a.strobe = 1'b1;
    @(negedge clk); a.strobe = 1'b0;
    checks++; if (a.seq_error !== 1'b1) begin errors++; $display("FAIL fresh_edge: got %b want 1", a.seq_error); end
    consume_and_clear();
  endtask

  task automatic test_high_first();
    pulse(1, 1'b1, 8'h24);
    pulse(1, 1'b0, 8'hB1);
    checks++; if (b.word_out !== 16'h24B1) begin errors++; $display("FAIL high_first_word: got %h want 24b1", b.word_out); end
    checks++; if ({b.word_valid, b.seq_error, b.overrun} !== 3'b100) begin errors++; $display("FAIL high_first_flags: got %b want 100", {b.word_valid, b.seq_error, b.overrun}); end
  endtask

  initial begin
    a.data_in = 8'h00; a.select = 1'b0; a.out_control = 1'b0; a.strobe = 1'b0;
    a.word_ready = 1'b0; a.clear_err = 1'b0;
    b.data_in = 8'h00; b.select = 1'b0; b.out_control = 1'b0; b.strobe = 1'b0;
    b.word_ready = 1'b0; b.clear_err = 1'b0;
    test_reset();
    test_word_assembly();
    test_overrun();
    test_seq_error();
    test_half_reselect();
    test_out_control();
    test_back_to_back();
    test_reset_mid();
    test_strobe_across_reset();
    test_high_first();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_pair_demux.md
BYTE_PAIR_DEMUX -- requirements
Module: byte_pair_demux

Interface
REQ-001 Parameter LOW_FIRST, default 1, SHALL select byte order: 1 = low byte then high byte, 0 = high byte then low byte.
REQ-002 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 data_in  input  8  multiplexed byte bus driven by the 2-to-1 byte mux.
REQ-005 select  input  1  mux select qualifier: 0 = byte is low half, 1 = byte is high half.
REQ-006 out_control  input  1  mux output enable, active-low; 1 = bus not driven, byte invalid.
REQ-007 strobe  input  1  synchronous byte-sample request from bus master.
REQ-008 word_out  output  16  assembled word {high, low}.
REQ-009 word_valid  output  1  word_out holds a complete unconsumed word.
REQ-010 word_ready  input  1  consumer accepts word_out.
REQ-011 overrun  output  1  sticky: byte arrived while a word was held.
REQ-012 seq_error  output  1  sticky: byte arrived with unexpected select.
REQ-013 clear_err  input  1  synchronous clear of overrun and seq_error.

Function
REQ-014 Capture event SHALL be: strobe rising edge (strobe=1 this cycle, registered strobe=0) AND out_control=0; strobe edges with out_control=1 SHALL be ignored without flags.
REQ-015 FSM SHALL have states IDLE (expect first byte), HALF (first byte stored, expect second), HOLD (word valid, wait for handshake).
REQ-016 IDLE: capture with expected first select -> store byte, go HALF; capture with wrong select -> set seq_error, discard byte, stay IDLE.
REQ-017 HALF: capture with expected second select -> load word_out, assert word_valid next cycle, go HOLD; capture with first-byte select -> set seq_error, overwrite stored first byte, stay HALF.
REQ-018 Latency from completing capture cycle to word_valid=1 SHALL be exactly 1 clock.
REQ-019 HOLD: word_valid=1 and word_ready=1 in the same cycle SHALL consume the word; word_valid=0 next cycle, go IDLE.
REQ-020 HOLD with capture and no handshake in the same cycle SHALL set overrun, drop the byte, keep word_out unchanged.
REQ-021 HOLD with handshake and a valid first-byte capture in the same cycle SHALL consume the word and store the byte, going directly to HALF; no overrun.
REQ-022 word_out SHALL be stable while word_valid=1 and SHALL retain the last word after consumption.
REQ-023 word_ready while word_valid=0 SHALL have no effect.
REQ-024 clear_err SHALL clear both sticky flags next cycle; a flag-setting event in the same cycle SHALL win (flag stays 1).

Reset
REQ-025 reset_n=0 SHALL immediately force state IDLE, word_out=16'h0000, word_valid=0, overrun=0, seq_error=0, stored byte=8'h00, registered strobe=0.
REQ-026 Reset asserted mid-word (HALF or HOLD) SHALL discard partial and held data; first capture after release SHALL be treated as a first byte.
REQ-027 A strobe held high across reset release SHALL NOT create a capture until it falls and rises again.

Structure
REQ-028 Shared package byte_pair_demux_pkg SHALL hold FSM state encodings (IDLE=2'd0, HALF=2'd1, HOLD=2'd2) and select constants SEL_LOW=1'b0, SEL_HIGH=1'b1.
REQ-029 One sub-module strobe_edge_detect (clk, reset_n, level in, single-cycle rise pulse out) SHALL implement REQ-014 edge detection.
REQ-030 Expected first/second select SHALL be derived from LOW_FIRST by constants, not by duplicated FSM logic.

Verification
REQ-031 LOW_FIRST=1: select=0 data 8'b10110001 strobe, then select=1 data 8'b00100100 strobe -> word_out=16'h24B1, word_valid=1 one clock after second capture, no flags.
REQ-032 Same sequence, word_ready=0 then third strobe (select=0) -> overrun=1, word_out stays 16'h24B1; word_ready=1 -> word_valid=0, IDLE.
REQ-033 IDLE, select=1 strobe -> seq_error=1, no word; clear_err pulse -> seq_error=0 next cycle; clear_err coincident with new error -> seq_error stays 1.
REQ-034 out_control=1 with strobe pulses and toggling select -> no state change, no flags, word_valid=0.
REQ-035 HOLD with word_ready=1 and select=0 strobe same cycle -> word consumed, state HALF, overrun=0; next select=1 strobe completes new word.
REQ-036 reset_n low during HALF and during HOLD -> all outputs zero immediately; LOW_FIRST=0 run of REQ-031 bytes in reverse order -> word_out=16'h24B1.
